soc_hash_stream: RTL and testbench
==================================

SOC_HASH_STREAM -- requirements
Module: soc_hash_stream

Interface
REQ-001 SHALL have parameter R, default 64, Hash core rate bits.
REQ-002 SHALL have parameter A, default 12, Hash core initial/final permutation rounds.
REQ-003 SHALL have parameter B, default 12, Hash core intermediate permutation rounds.
REQ-004 SHALL have parameter H, default 256, Hash core hash-size parameter.
REQ-005 SHALL have parameter L, default 256, digest length in bits.
REQ-006 SHALL have parameter Y, default 512, maximum message length in bits (Hash core message width).
REQ-007 SHALL have parameter W, default 8, stream word width; W divides Y and L; legal W: 8, 16, 32, 64.
REQ-008 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port in_valid, input, 1, message word offered.
REQ-011 SHALL have port in_data, input, W, message word, MSB first.
REQ-012 SHALL have port in_last, input, 1, qualifies final message word.
REQ-013 SHALL have port in_ready, output, 1, block accepts a message word.
REQ-014 SHALL have port out_valid, output, 1, digest word offered.
REQ-015 SHALL have port out_data, output, W, digest word, MSB first.
REQ-016 SHALL have port out_last, output, 1, qualifies final digest word.
REQ-017 SHALL have port out_ready, input, 1, sink accepts digest word.
REQ-018 SHALL have port busy, output, 1, high in every state except LOAD.
REQ-019 SHALL have port ovf, output, 1, sticky: message reached Y bits without in_last.
REQ-020 SHALL have port msg_words, output, 16, count of words accepted in current/last message.

Function
REQ-021 SHALL instantiate the Hash core with R,A,B,H,L,Y; core reset input driven by ~rst.
REQ-022 SHALL implement FSM LOAD -> START -> RUN -> DRAIN -> LOAD; reset state LOAD.
REQ-023 LOAD: in_ready = 1 while msg_words < Y/W; transfer occurs when in_valid && in_ready.
REQ-024 On each transfer, the message register SHALL shift left by W and insert in_data in the low W bits; msg_words increments by 1.
REQ-025 On leaving LOAD, the message register SHALL be left-aligned: shifted left by Y - W*msg_words, zero fill; alignment SHALL complete within START.
REQ-026 Transfer with in_last=1, or transfer of word number Y/W, SHALL move FSM to START next cycle.
REQ-027 Reaching Y/W words with in_last=0 SHALL set ovf; ovf cleared only by rst or first transfer of the next message.
REQ-028 in_last with zero words is impossible; in_valid with in_last on the first word SHALL yield a 1-word message.
REQ-029 START SHALL last exactly one cycle and assert core start for that cycle only; in_ready = 0.
REQ-030 RUN SHALL wait for core ready; ignore in_valid (in_ready = 0); out_valid = 0.
REQ-031 The cycle after core ready is seen, the digest SHALL be latched into an L-bit output register and FSM SHALL enter DRAIN.
REQ-032 DRAIN: out_valid = 1; out_data = word k of the latched digest (bits L-1-k*W down to L-W-k*W), k from 0.
REQ-033 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-034 On out_valid && out_ready, k increments; out_last = 1 when k = L/W - 1.
REQ-035 Handshake on the last word SHALL return FSM to LOAD next cycle, clear msg_words and the message register, set k = 0.
REQ-036 Latency from in_last transfer to first out_valid SHALL be 2 cycles plus core latency (START + latch), with no added bubbles between digest words under continuous out_ready.

Reset
REQ-037 rst SHALL, at the next edge and in any state: FSM = LOAD, in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, busy = 0, ovf = 0, msg_words = 0, message and digest registers = 0.
REQ-038 rst mid-RUN or mid-DRAIN SHALL discard the operation; the next message SHALL hash correctly.

Verification
REQ-039 W=8: bytes 0x61,0x62,0x63 (last on 0x63) -> core message = 0x616263 followed by 488 zero bits; 32 digest bytes match golden model; out_last on byte 32 only.
REQ-040 W=8: 64 bytes 0x00..0x3F, in_last on 0x3F -> ovf = 0, msg_words = 64, digest matches golden model.
REQ-041 W=8: 65 bytes, no in_last -> in_ready low after byte 64, ovf = 1, byte 65 not accepted, hash proceeds on 64 bytes.
REQ-042 out_ready low 5 cycles on digest word 3 -> out_data unchanged for 5 cycles, k advances only on handshake, 32 words total.
REQ-043 rst asserted during DRAIN at word 10 -> next cycle out_valid = 0, in_ready = 1; new message 0x00 yields correct full digest.
REQ-044 W=32: 2 words 0xDEADBEEF, 0x01234567 with last -> 8 output words, out_last on word 8, digest matches golden model.

Source files
------------

// File: rtl/soc_hash_stream.sv
// Streaming front end for a sponge hash core: collect a message word by word,
// hash the left-aligned Y-bit message in one shot, then stream the digest out.

module soc_hash_core #(
  parameter int R = 64,
  parameter int A = 12,
  parameter int B = 12,
  parameter int H = 256,
  parameter int L = 256,
  parameter int Y = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [Y-1:0] msg,
  output logic         ready,
  output logic [L-1:0] digest
);
  localparam int NB = Y / R;
  localparam int NS = L / R;
  localparam logic [63:0] IV = {8'h00, 8'(R), 8'(A), 8'(A - B), 32'(H)};
  localparam logic [1:0] C_IDLE = 2'd0, C_PERM = 2'd1, C_STEP = 2'd2;

  logic [1:0]   phase;
  logic [3:0]   rnd;
  logic [7:0]   step;
  logic [319:0] st;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One permutation round; rnd counts up to 11 so shorter permutations use the tail constants.
  function automatic logic [319:0] perm_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, ~i, i};
    x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
    x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
    return {x0 ^ rotr(x0, 19) ^ rotr(x0, 28),
            x1 ^ rotr(x1, 61) ^ rotr(x1, 39),
            x2 ^ rotr(x2, 1)  ^ rotr(x2, 6),
            x3 ^ rotr(x3, 10) ^ rotr(x3, 17),
            x4 ^ rotr(x4, 7)  ^ rotr(x4, 41)};
  endfunction

  assign ready = (phase == C_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase  <= C_IDLE;
      rnd    <= '0;
      step   <= '0;
      st     <= '0;
      digest <= '0;
    end else begin
      case (phase)
        C_IDLE: if (start) begin
          st     <= {IV, 256'd0};
          rnd    <= 4'(12 - A);
          step   <= '0;
          digest <= '0;
          phase  <= C_PERM;
        end
        C_PERM: begin
          st  <= perm_round(st, rnd);
          rnd <= rnd + 4'd1;
          if (rnd == 4'd11) phase <= C_STEP;
        end
        C_STEP: begin
          if (step < 8'(NB)) begin
            st[319:256] <= st[319:256] ^ msg[Y-1-int'(step)*R -: R];
            rnd   <= (step == 8'(NB - 1)) ? 4'(12 - A) : 4'(12 - B);
            step  <= step + 8'd1;
            phase <= C_PERM;
          end else begin
            digest <= {digest[L-R-1:0], st[319:256]};
            if (step == 8'(NB + NS - 1)) begin
              phase <= C_IDLE;
            end else begin
              rnd   <= 4'(12 - B);
              step  <= step + 8'd1;
              phase <= C_PERM;
            end
          end
        end
        default: phase <= C_IDLE;
      endcase
    end
  end
endmodule

// state | meaning
// LOAD  | accept message words until in_last or the register is full
// START | message aligned, one-cycle start pulse to the core
// RUN   | wait for the core to finish
// DRAIN | stream the latched digest out, W bits per handshake
module soc_hash_stream #(
  parameter int R = 64,
  parameter int A = 12,
  parameter int B = 12,
  parameter int H = 256,
  parameter int L = 256,
  parameter int Y = 512,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         ovf,
  output logic [15:0]  msg_words
);
  localparam int NW = Y / W;
  localparam int NO = L / W;
  localparam logic [1:0] S_LOAD = 2'd0, S_START = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3;

  logic [1:0]   state;
  logic [Y-1:0] msg;
  logic [Y-1:0] msg_next;
  logic [L-1:0] dig;
  logic [L-1:0] core_digest;
  logic [15:0]  k;
  logic         core_ready;
  logic         xfer;
  logic         end_msg;
  logic         out_hs;

  assign in_ready  = (state == S_LOAD) && (msg_words < 16'(NW));
  assign xfer      = in_valid && in_ready;
  assign end_msg   = xfer && (in_last || (msg_words == 16'(NW - 1)));
  assign msg_next  = {msg[Y-W-1:0], in_data};
  assign out_valid = (state == S_DRAIN);
  assign out_data  = dig[L-1 -: W];
  assign out_last  = out_valid && (k == 16'(NO - 1));
  assign out_hs    = out_valid && out_ready;
  assign busy      = (state != S_LOAD);

  soc_hash_core #(.R(R), .A(A), .B(B), .H(H), .L(L), .Y(Y)) u_core (
    .clk    (clk),
    .rst_n  (~rst),
    .start  (state == S_START),
    .msg    (msg),
    .ready  (core_ready),
    .digest (core_digest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      msg       <= '0;
      dig       <= '0;
      k         <= '0;
      msg_words <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (xfer) begin
          msg_words <= msg_words + 16'd1;
          if (msg_words == 16'd0) ovf <= 1'b0;
          if ((msg_words == 16'(NW - 1)) && !in_last) ovf <= 1'b1;
          // Left-align on the final word so the core always sees MSB-first data.
          if (end_msg) begin
            msg   <= msg_next << (Y - W * (int'(msg_words) + 1));
            state <= S_START;
          end else begin
            msg <= msg_next;
          end
        end
        S_START: state <= S_RUN;
        S_RUN: if (core_ready) begin
          dig   <= core_digest;
          k     <= '0;
          state <= S_DRAIN;
        end
        S_DRAIN: if (out_hs) begin
          dig <= dig << W;
          if (k == 16'(NO - 1)) begin
            k         <= '0;
            msg_words <= '0;
            msg       <= '0;
            state     <= S_LOAD;
          end else begin
            k <= k + 16'd1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_hash_stream.sv
// Randomized bench for soc_hash_stream with a column-wise S-box reference model
// of the sponge hash and a per-cycle digest stream checker.

module tb_soc_hash_stream;
  localparam int A = 12;
  localparam int B = 12;

  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid8 = 1'b0, in_last8 = 1'b0, in_ready8, out_valid8, out_last8, busy8, ovf8;
  logic [7:0]  in_data8 = '0, out_data8;
  logic        out_ready8 = 1'b1;
  logic [15:0] msg_words8;
  logic        in_valid32 = 1'b0, in_last32 = 1'b0, in_ready32, out_valid32, out_last32, busy32, ovf32;
  logic [31:0] in_data32 = '0, out_data32;
  logic        out_ready32 = 1'b1;
  logic [15:0] msg_words32;

  soc_hash_stream #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_data(in_data8), .in_last(in_last8),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8), .out_last(out_last8),
    .out_ready(out_ready8), .busy(busy8), .ovf(ovf8), .msg_words(msg_words8));

  soc_hash_stream #(.W(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_data(in_data32), .in_last(in_last32),
    .in_ready(in_ready32), .out_valid(out_valid32), .out_data(out_data32), .out_last(out_last32),
    .out_ready(out_ready32), .busy(busy32), .ovf(ovf32), .msg_words(msg_words32));

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp8[$];
  logic [31:0] exp32[$];
  int widx8 = 0, widx32 = 0;
  int stall_at = -1, stall_cnt = 0, stall_seen = 0;
  bit rand_rdy = 1'b0;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  function automatic logic [0:4][63:0] perm(input logic [0:4][63:0] s, input int nr);
    logic [0:4][63:0] t;
    logic [4:0] col;
    for (int r = 12 - nr; r < 12; r++) begin
      s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
        for (int i = 0; i < 5; i++) t[i][b] = col[4 - i];
      end
      for (int i = 0; i < 5; i++) s[i] = t[i] ^ ror(t[i], ROT_A[i]) ^ ror(t[i], ROT_B[i]);
    end
    return s;
  endfunction

  function automatic logic [255:0] model_hash(input logic [511:0] m);
    logic [0:4][63:0] s;
    logic [255:0] d;
    s = '0;
    s[0] = {8'h00, 8'd64, 8'd12, 8'd0, 32'd256};
    s = perm(s, A);
    for (int i = 0; i < 8; i++) begin
      s[0] = s[0] ^ m[511 - 64*i -: 64];
      s = perm(s, (i == 7) ? A : B);
    end
    for (int j = 0; j < 4; j++) begin
      d[255 - 64*j -: 64] = s[0];
      if (j < 3) s = perm(s, B);
    end
    return d;
  endfunction

  function automatic logic [511:0] build8(input logic [7:0] b[$]);
    logic [511:0] m;
    m = '0;
    foreach (b[i]) m = {m[503:0], b[i]};
    return m << (512 - 8 * b.size());
  endfunction

  function automatic void push8(input logic [511:0] m);
    logic [255:0] d;
    d = model_hash(m);
    for (int j = 0; j < 32; j++) exp8.push_back(d[255 - 8*j -: 8]);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send8(input logic [7:0] b[$], input bit with_last, input int gap_pct);
    int i = 0;
    int guard = 0;
    while (i < b.size() && guard < 5000) begin
      in_valid8 = ($urandom_range(0, 99) >= gap_pct);
      in_data8  = b[i];
      in_last8  = with_last && (i == b.size() - 1);
      @(negedge clk);
      if (in_valid8 && in_ready8) i++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid8 = 1'b0;
    in_last8  = 1'b0;
    chk("send8_timeout", guard < 5000, 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy8 || busy32 || exp8.size() != 0 || exp32.size() != 0) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_timeout"}, n < 4000, 1);
  endtask

  // ---------------- output drivers / checkers ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (out_valid8 && widx8 == stall_at && stall_cnt < 5) begin
        out_ready8 = 1'b0;
        stall_cnt++;
      end else begin
        out_ready8 = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  logic       pv8 = 1'b0, pr8 = 1'b0, pl8 = 1'b0;
  logic [7:0] pd8 = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv8 = 1'b0;
    end else begin
      if (pv8 && !pr8) begin
        chk("hold_valid8", out_valid8, 1);
        chk("hold_data8", out_data8, pd8);
        chk("hold_last8", out_last8, pl8);
      end
      if (pv8 && pr8 && !pl8) chk("no_bubble8", out_valid8, 1);
      if (out_valid8 && !out_ready8) stall_seen++;
      if (out_valid8 && out_ready8) begin
        if (exp8.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word8: got %0h expected no word", out_data8);
        end else begin
          chk("data8", out_data8, exp8.pop_front());
          chk("last8", out_last8, widx8 == 31);
        end
        widx8 = (widx8 == 31) ? 0 : widx8 + 1;
      end
      pv8 = out_valid8; pr8 = out_ready8; pd8 = out_data8; pl8 = out_last8;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid32 && out_ready32) begin
      if (exp32.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_word32: got %0h expected no word", out_data32);
      end else begin
        chk("data32", out_data32, exp32.pop_front());
        chk("last32", out_last32, widx32 == 7);
      end
      widx32 = (widx32 == 7) ? 0 : widx32 + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] q[$];
    logic [511:0] m;
    logic [255:0] d;
    int n, guard;
    bit lst;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_out_last", out_last8, 0);
    chk("rst_out_data", out_data8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_msg_words", msg_words8, 0);
    rst = 1'b0;

    // "abc"
    q = '{8'h61, 8'h62, 8'h63};
    chk("model_align_abc", build8(q), {24'h616263, 488'd0});
    push8(build8(q));
    send8(q, 1'b1, 30);
    chk("abc_core_msg", u_dut8.msg, {24'h616263, 488'd0});
    chk("abc_msg_words", msg_words8, 3);
    chk("abc_busy", busy8, 1);
    chk("abc_in_ready", in_ready8, 0);
    wait_done("abc");

    // 64 bytes 0x00..0x3F, last on the final byte
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(8'(i));
    push8(build8(q));
    send8(q, 1'b1, 0);
    chk("full_msg_words", msg_words8, 64);
    chk("full_ovf", ovf8, 0);
    wait_done("full");

    // 65 bytes without in_last: only 64 consumed, ovf sticky
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(8'($urandom));
    push8(build8(q));
    send8(q, 1'b0, 20);
    chk("ovf_set", ovf8, 1);
    chk("ovf_msg_words", msg_words8, 64);
    in_valid8 = 1'b1; in_data8 = 8'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_byte65_ready", in_ready8, 0);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    chk("ovf_byte65_words", msg_words8, 64);
    wait_done("ovf");
    chk("ovf_sticky", ovf8, 1);
    chk("ovf_words_cleared", msg_words8, 0);

    // back-pressure: out_ready low for 5 cycles on digest word 3
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    push8(build8(q));
    stall_at = 3; stall_cnt = 0; stall_seen = 0;
    send8(q, 1'b1, 0);
    chk("ovf_cleared", ovf8, 0);
    wait_done("stall");
    chk("stall_cycles", stall_seen, 5);
    stall_at = -1;

    // reset during DRAIN at word 10
    q.delete();
    for (int i = 0; i < 7; i++) q.push_back(8'($urandom));
    push8(build8(q));
    send8(q, 1'b1, 0);
    guard = 0;
    while (!(out_valid8 && widx8 == 10) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain10_reached", guard < 2000, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid8, 0);
    chk("mid_rst_in_ready", in_ready8, 1);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_words", msg_words8, 0);
    chk("mid_rst_data", out_data8, 0);
    exp8.delete();
    widx8 = 0;
    rst = 1'b0;
    q = '{8'h00};
    push8(build8(q));
    send8(q, 1'b1, 0);
    chk("after_rst_words", msg_words8, 1);
    wait_done("after_rst");

    // randomized messages with random gaps and back-pressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 64);
      lst = (n < 64) ? 1'b1 : 1'($urandom_range(0, 1));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      push8(build8(q));
      send8(q, lst, 25);
      chk("rand_words", msg_words8, n);
      chk("rand_ovf", ovf8, (n == 64) && !lst);
      wait_done("rand");
    end
    rand_rdy = 1'b0;

    // 32-bit stream: two words with last
    m = {32'hDEADBEEF, 32'h01234567, 448'd0};
    d = model_hash(m);
    for (int j = 0; j < 8; j++) exp32.push_back(d[255 - 32*j -: 32]);
    for (int i = 0; i < 2; i++) begin
      in_valid32 = 1'b1;
      in_data32  = (i == 0) ? 32'hDEADBEEF : 32'h01234567;
      in_last32  = (i == 1);
      @(negedge clk);
      chk("w32_in_ready", in_ready32, 1);
      @(posedge clk); #1;
    end
    in_valid32 = 1'b0; in_last32 = 1'b0;
    chk("w32_core_msg", u_dut32.msg, m);
    chk("w32_msg_words", msg_words32, 2);
    wait_done("w32");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
